audio_dac_stream: RTL
=====================

AUDIO_DAC_STREAM -- requirements
Module: audio_dac_stream

Interface
- REQ-001 The block SHALL have these parameters:
  - SAMPLE_W, 24, sample width in bits (8..32).
  - NUM_CH, 2, channels per frame (1..8).
  - SLOT_W, 32, bit clocks per channel slot (must be >= SAMPLE_W).
  - FIFO_DEPTH, 64, frame FIFO depth (power of 2, >= 4).
  - MODE, 0, framing mode: 0 = I2S, 1 = left-justified/TDM.
- REQ-002 The block SHALL have these ports, clock and reset first:
  - clk  in  1  system clock.
  - reset  in  1  reset, asynchronous, active-high.
  - enable  in  1  streaming enable.
  - in_data  in  NUM_CH*SAMPLE_W  one frame; channel 0 in the LSB slice.
  - in_valid  in  1  frame offered.
  - in_ready  out  1  frame accepted when in_valid && in_ready.
  - audio_BCLK  in  1  codec bit clock (asynchronous to clk).
  - audio_DACLRCK  in  1  codec frame clock (asynchronous to clk).
  - audio_DACDAT  out  1  serial sample data.
  - fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
  - underrun  out  1  sticky underrun flag.
  - underrun_clr  in  1  clears underrun.
- REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and reset.

Function
- REQ-004 audio_BCLK and audio_DACLRCK SHALL each pass through a 2-FF synchroniser plus one edge-detect register in the clk domain.
- REQ-005 The block SHALL require clk >= 8x BCLK; behaviour below that ratio is undefined.
- REQ-006 A frame-start event SHALL be:
  - MODE=0: a synchronised DACLRCK falling edge.
  - MODE=1: a synchronised DACLRCK rising edge.
- REQ-007 audio_DACDAT SHALL change only on synchronised BCLK falling edges, and within 3 clk cycles of the raw BCLK fall.
- REQ-008 The serial bit sequence SHALL be:
  - MODE=0: one idle bit clock after frame start, then data.
  - MODE=1: data begins on the first BCLK fall after frame start.
- REQ-009 Channel c SHALL occupy bit clocks c*SLOT_W .. c*SLOT_W+SLOT_W-1 of the frame, MSB first.
- REQ-010 Slot bits beyond SAMPLE_W, and all bits after NUM_CH slots until the next frame start, SHALL drive 0.
- REQ-011 At each frame start with enable=1 and the FIFO non-empty, the block SHALL pop one frame into the shift register in that same clk cycle.
- REQ-012 At a frame start with enable=1 and the FIFO empty, the block SHALL load an all-zero frame and set underrun.
- REQ-013 underrun SHALL remain set until underrun_clr=1.
- REQ-014 If underrun_clr and a new underrun coincide, the set SHALL win.
- REQ-015 With enable=0:
  - audio_DACDAT SHALL be 0 and no pop SHALL occur.
  - the FIFO SHALL still accept writes.
- REQ-016 An enable rise mid-frame SHALL take effect at the next frame start; an enable fall mid-frame SHALL force DACDAT to 0 immediately.
- REQ-017 in_ready SHALL equal (fifo_level < FIFO_DEPTH) and be registered; a write is refused when full, even if a pop occurs in the same cycle.
- REQ-018 A simultaneous push and pop when not full SHALL leave fifo_level unchanged.
- REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL never exceed FIFO_DEPTH nor underflow.
- REQ-020 The 1-bit state machine SHALL have states IDLE and SHIFT:
  - IDLE to SHIFT on a frame start with enable=1.
  - SHIFT to IDLE after NUM_CH*SLOT_W bits (plus the delay bit), or on enable=0.
  - SHIFT to SHIFT (reload) on a frame start arriving early.

Reset
- REQ-021 Reset SHALL set the following to 0 asynchronously: FIFO pointers, fifo_level, shift register, bit counter, synchronisers, audio_DACDAT and underrun; the state machine SHALL go to IDLE.
- REQ-022 in_ready SHALL be 0 during reset and 1 on the first clk cycle after reset deasserts.
- REQ-023 After reset release, the first pop SHALL occur no earlier than the first detected frame start.

Structure
- REQ-024 Package dac_pkg SHALL hold:
  - the MODE encodings (DAC_I2S=0, DAC_LJ=1);
  - default parameter constants;
  - the frame-width function NUM_CH*SAMPLE_W.
- REQ-025 The frame FIFO SHALL be the sub-module stream_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, level), reusable by the esp_uart path.

Verification
- REQ-026 The bench SHALL cover these directed scenarios:
  - MODE=0, SAMPLE_W=24, SLOT_W=32, BCLK=clk/16; push L=0xA5A5A5, R=0x5A5A5A -> after the LRCK fall, 1 idle bit, 24 bits 0xA5A5A5 MSB first, 8 zeros, then R in the high-LRCK half.
  - MODE=1, NUM_CH=4, SLOT_W=16, SAMPLE_W=16; frames 0x1111/0x2222/0x3333/0x4444 -> four 16-bit slots start on the first BCLK fall after the LRCK rise.
  - Empty FIFO with enable=1 for 3 frames -> DACDAT all 0 and underrun=1; underrun_clr pulse -> 0; clear coinciding with an underrun frame start -> stays 1.
  - Push 70 frames, DEPTH=64, no LRCK -> in_ready falls after 64, fifo_level=64; one frame start -> level 63 and in_ready=1 next cycle.
  - enable deasserted mid-slot -> DACDAT=0 within 1 clk; re-assert mid-frame -> output resumes only at the next frame start with a fresh pop.
  - reset asserted mid-frame with the FIFO at 10 -> level=0, DACDAT=0, underrun=0 immediately; first pop only at the next frame start after release.

Source files
------------

// File: rtl/audio_dac_stream_pkg.sv
// Shared encodings, defaults and helpers for the audio DAC streaming path.
package dac_pkg;

    localparam int DAC_I2S = 0;
    localparam int DAC_LJ  = 1;

    localparam int DEF_SAMPLE_W   = 24;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_SLOT_W     = 32;
    localparam int DEF_FIFO_DEPTH = 64;
    localparam int DEF_MODE       = DAC_I2S;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } dac_state_e;

    function automatic int frame_width(input int num_ch, input int sample_w);
        return num_ch * sample_w;
    endfunction

endpackage

// File: rtl/audio_dac_stream_fifo.sv
// Show-ahead synchronous FIFO; a push while full is dropped even if a pop coincides.
module stream_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = (level_q == LVL_MAX);
        empty    = (level_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        rd_data = mem_q[rd_ptr_q];
        level   = level_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/audio_dac_stream.sv
// Frame FIFO feeding an I2S / left-justified-TDM serialiser clocked by a codec's BCLK/LRCK.
module audio_dac_stream
    import dac_pkg::*;
#(
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SLOT_W     = DEF_SLOT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MODE       = DEF_MODE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_CH*SAMPLE_W-1:0]    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          audio_BCLK,
    input  logic                          audio_DACLRCK,
    output logic                          audio_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr
);

    localparam int FRAME_W = frame_width(NUM_CH, SAMPLE_W);
    localparam int SHIFT_W = NUM_CH * SLOT_W;
    localparam int CNT_W   = $clog2(SHIFT_W + 1);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic bclk_s1_q, bclk_s2_q, bclk_d_q;
    logic lrck_s1_q, lrck_s2_q, lrck_d_q;
    logic bclk_fall, frame_start;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FRAME_W-1:0] fifo_rdata;
    logic [LVL_W-1:0]   level;
    logic               ready_q, ready_d;

    dac_state_e         state_q, state_d;
    logic [SHIFT_W-1:0] sh_q, sh_d, sh_eff, load_frame;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_eff;
    logic               dly_q, dly_d, dly_eff;
    logic               dac_q, dac_d;
    logic               underrun_q, underrun_d;
    logic               active;

    assign bclk_fall   = bclk_d_q && !bclk_s2_q;
    assign frame_start = (MODE == DAC_LJ) ? (!lrck_d_q && lrck_s2_q)
                                          : (lrck_d_q && !lrck_s2_q);

    assign fifo_push = in_valid && ready_q;
    assign fifo_pop  = frame_start && enable && !fifo_empty;

    stream_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Next-cycle level is full only if a full FIFO is not popped or the last free entry fills.
    assign ready_d = !((fifo_full && !fifo_pop) ||
                       (level == LVL_W'(FIFO_DEPTH - 1) && fifo_push && !fifo_pop));

    always_comb begin
        load_frame = '0;
        if (!fifo_empty) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                load_frame[SHIFT_W-1-c*SLOT_W -: SAMPLE_W] = fifo_rdata[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // A frame start may coincide with a BCLK fall, so the fall acts on the freshly loaded frame.
    always_comb begin
        state_d    = state_q;
        dac_d      = dac_q;
        underrun_d = underrun_q && !underrun_clr;
        sh_eff     = sh_q;
        cnt_eff    = cnt_q;
        dly_eff    = dly_q;
        active     = (state_q == ST_SHIFT);
        if (!enable) begin
            state_d = ST_IDLE;
            dac_d   = 1'b0;
        end else begin
            if (frame_start) begin
                sh_eff  = load_frame;
                cnt_eff = '0;
                dly_eff = (MODE == DAC_I2S);
                active  = 1'b1;
                state_d = ST_SHIFT;
                if (fifo_empty) underrun_d = 1'b1;
            end
            if (bclk_fall) begin
                if (!active) begin
                    dac_d = 1'b0;
                end else if (dly_eff) begin
                    dac_d   = 1'b0;
                    dly_eff = 1'b0;
                end else if (cnt_eff == CNT_LAST) begin
                    dac_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    dac_d   = sh_eff[SHIFT_W-1];
                    sh_eff  = {sh_eff[SHIFT_W-2:0], 1'b0};
                    cnt_eff = cnt_eff + CNT_ONE;
                end
            end
        end
        sh_d  = sh_eff;
        cnt_d = cnt_eff;
        dly_d = dly_eff;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_s1_q  <= 1'b0;
            bclk_s2_q  <= 1'b0;
            bclk_d_q   <= 1'b0;
            lrck_s1_q  <= 1'b0;
            lrck_s2_q  <= 1'b0;
            lrck_d_q   <= 1'b0;
            ready_q    <= 1'b0;
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            dly_q      <= 1'b0;
            dac_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            bclk_s1_q  <= audio_BCLK;
            bclk_s2_q  <= bclk_s1_q;
            bclk_d_q   <= bclk_s2_q;
            lrck_s1_q  <= audio_DACLRCK;
            lrck_s2_q  <= lrck_s1_q;
            lrck_d_q   <= lrck_s2_q;
            ready_q    <= ready_d;
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            dac_q      <= dac_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_ready     = ready_q;
    assign audio_DACDAT = dac_q;
    assign fifo_level   = level;
    assign underrun     = underrun_q;

endmodule
